// File: rtl/ascon_pkg.sv
// Shared types for the ASCON substitution layer: state array, sizes, FSM states,
// and pack/unpack helpers between the flat 320-bit bus and the five 64-bit words.
package ascon_pkg;

    localparam int STATE_W = 320;
    localparam int COL_NB  = 64;

    typedef logic [63:0] state_t [0:4];

    typedef enum logic [1:0] {
        IDLE,
        SUBST,
        DONE
    } sub_state_t;

    // x0 occupies the top word of the flat bus, x4 the bottom one
    function automatic state_t unpack_state(input logic [STATE_W-1:0] v);
        state_t s;
        for (int i = 0; i < 5; i++) begin
            s[i] = v[STATE_W-1-64*i -: 64];
        end
        return s;
    endfunction

    function automatic logic [STATE_W-1:0] pack_state(input state_t s);
        logic [STATE_W-1:0] v;
        for (int i = 0; i < 5; i++) begin
            v[STATE_W-1-64*i -: 64] = s[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/ascon_sub_layer_ctrl_sbox.sv
// ASCON 5-bit substitution box in bit-sliced form.
// i_col[4] is x0, i_col[0] is x4; output uses the same mapping.
module ascon_sub_layer_ctrl_sbox (
    input  logic [4:0] i_col,
    output logic [4:0] o_col
);

    logic w_a0, w_a1, w_a2, w_a3, w_a4;
    logic w_b0, w_b1, w_b2, w_b3, w_b4;

    assign w_a0 = i_col[4] ^ i_col[0];
    assign w_a1 = i_col[3];
    assign w_a2 = i_col[2] ^ i_col[3];
    assign w_a3 = i_col[1];
    assign w_a4 = i_col[0] ^ i_col[1];

    // chi-like nonlinear step
    assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
    assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
    assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
    assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
    assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

    assign o_col[4] = w_b0 ^ w_b4;
    assign o_col[3] = w_b1 ^ w_b0;
    assign o_col[2] = ~w_b2;
    assign o_col[1] = w_b3 ^ w_b2;
    assign o_col[0] = w_b4;

endmodule

// File: rtl/ascon_sub_layer_ctrl.sv
// ASCON substitution layer: NB_SBOX sboxes swept over 64 columns, start/ready in, valid/ack out.
// Define ASCON_ROUND_CST_EN to add rc_i, XORed into x2[7:0] when the state is captured.
import ascon_pkg::*;

module ascon_sub_layer_ctrl #(
    parameter int NB_SBOX = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [STATE_W-1:0] state_i,
`ifdef ASCON_ROUND_CST_EN
    input  logic [7:0]         rc_i,
`endif
    output logic               ready_o,
    output logic               valid_o,
    input  logic               ack_i,
    output logic [STATE_W-1:0] state_o
);

    localparam int NB_STEPS = COL_NB / NB_SBOX;
    localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;

    if (!(NB_SBOX == 1 || NB_SBOX == 2 || NB_SBOX == 4 || NB_SBOX == 8 ||
          NB_SBOX == 16 || NB_SBOX == 32 || NB_SBOX == 64)) begin : g_bad_nb
        $error("NB_SBOX must be a power of two from 1 to 64");
    end

    sub_state_t       r_fsm;
    sub_state_t       w_fsm_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    state_t           r_state;
    state_t           w_cap;

    logic [5:0] w_col    [NB_SBOX];
    logic [4:0] w_sb_in  [NB_SBOX];
    logic [4:0] w_sb_out [NB_SBOX];

    assign w_last = (r_cnt == CNT_W'(NB_STEPS - 1));

    always_comb begin
        w_cap = unpack_state(state_i);
`ifdef ASCON_ROUND_CST_EN
        w_cap[2][7:0] = w_cap[2][7:0] ^ rc_i;
`endif
    end

    // each sbox k works on column cnt*NB_SBOX + k this cycle
    for (genvar k = 0; k < NB_SBOX; k++) begin : g_sbox
        assign w_col[k] = 6'(r_cnt * NB_SBOX + k);

        assign w_sb_in[k] = {r_state[0][w_col[k]],
                             r_state[1][w_col[k]],
                             r_state[2][w_col[k]],
                             r_state[3][w_col[k]],
                             r_state[4][w_col[k]]};

        ascon_sub_layer_ctrl_sbox u_sbox (
            .i_col (w_sb_in[k]),
            .o_col (w_sb_out[k])
        );
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            IDLE:    if (start_i) w_fsm_nxt = SUBST;
            SUBST:   if (w_last)  w_fsm_nxt = DONE;
            DONE:    if (ack_i)   w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= '{default: '0};
            r_cnt   <= '0;
        end else if (r_fsm == IDLE && start_i) begin
            r_state <= w_cap;
            r_cnt   <= '0;
        end else if (r_fsm == SUBST) begin
            for (int k = 0; k < NB_SBOX; k++) begin
                for (int b = 0; b < 5; b++) begin
                    r_state[b][w_col[k]] <= w_sb_out[k][4-b];
                end
            end
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign ready_o = (r_fsm == IDLE);
    assign valid_o = (r_fsm == DONE);
    assign state_o = pack_state(r_state);

endmodule

// File: tb/tb_ascon_sub_layer_ctrl.sv
// Self-checking bench for ascon_sub_layer_ctrl with NB_SBOX = 8, 1 and 64.
// Results are compared with a table-driven sbox model applied column by column.
module tb_ascon_sub_layer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start [3];
    logic         ack   [3];
    logic [319:0] sti   [3];
    logic         ready [3];
    logic         valid [3];
    logic [319:0] sto   [3];
    logic [7:0]   rc;

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ascon_sub_layer_ctrl #(
            .NB_SBOX (g == 0 ? 8 : (g == 1 ? 1 : 64))
        ) u_dut (
            .clock_i (clk),
            .reset_i (rst),
            .start_i (start[g]),
            .state_i (sti[g]),
`ifdef ASCON_ROUND_CST_EN
            .rc_i    (rc),
`endif
            .ready_o (ready[g]),
            .valid_o (valid[g]),
            .ack_i   (ack[g]),
            .state_o (sto[g])
        );
    end

    localparam logic [4:0] SB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic int nb_of(input int sel);
        return (sel == 0) ? 8 : ((sel == 1) ? 1 : 64);
    endfunction

    function automatic logic [7:0] rc_eff();
`ifdef ASCON_ROUND_CST_EN
        return rc;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [319:0] ref_sub(input logic [319:0] s, input logic [7:0] r);
        logic [63:0] x [5];
        logic [4:0]  v;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
        x[2][7:0] = x[2][7:0] ^ r;
        for (int j = 0; j < 64; j++) begin
            v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
            o = SB[v];
            for (int i = 0; i < 5; i++) x[i][j] = o[4-i];
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_start(input int sel, input logic [319:0] st);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ready[sel]) begin
            errors++;
            $display("FAIL start_wait dut=%0d ready=%b required=1", sel, ready[sel]);
        end
        start[sel] = 1'b1;
        sti[sel]   = st;
        @(posedge clk);
        #1;
        start[sel] = 1'b0;
    endtask

    // lat counts cycles after the start cycle; 1 = the cycle right after acceptance
    task automatic wait_valid(input int sel, output int lat);
        lat = 1;
        while (!valid[sel] && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!valid[sel]) lat = -1;
    endtask

    task automatic do_ack(input int sel);
        @(negedge clk);
        ack[sel] = 1'b1;
        @(posedge clk);
        #1;
        ack[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rc  = 8'h00;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0;
            ack[g]   = 1'b0;
            sti[g]   = '1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (ready[g] !== 1'b1 || valid[g] !== 1'b0 || sto[g] !== '0) begin
                errors++;
                $display("FAIL reset dut=%0d ready=%b valid=%b state=%h required 1/0/0",
                         g, ready[g], valid[g], sto[g]);
            end
        end
    endtask

    task automatic test_zero_state();
        int lat;
        logic [319:0] exp;
        exp = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
        do_start(0, '0);
        wait_valid(0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL zero_latency got=%0d required=9", lat);
        end
        checks++;
        if (sto[0] !== exp) begin
            errors++;
            $display("FAIL zero_state got=%h required=%h", sto[0], exp);
        end
        do_ack(0);
    endtask

    task automatic test_ones_state();
        int lat;
        logic [319:0] exp;
        exp = {{64{1'b1}}, 64'h0, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}};
        do_start(0, '1);
        wait_valid(0, lat);
        checks++;
        if (sto[0] !== exp || lat !== 9) begin
            errors++;
            $display("FAIL ones_state lat=%0d got=%h required=%h", lat, sto[0], exp);
        end
        do_ack(0);
    endtask

    task automatic test_random();
        int lat;
        logic [319:0] st;
        logic [319:0] exp;
        for (int i = 0; i < 6; i++) begin
            st = rand320();
            rc = 8'($urandom);
            exp = ref_sub(st, rc_eff());
            do_start(0, st);
            wait_valid(0, lat);
            checks++;
            if (sto[0] !== exp || lat !== 9) begin
                errors++;
                $display("FAIL random_%0d lat=%0d got=%h required=%h", i, lat, sto[0], exp);
            end
            do_ack(0);
        end
        rc = 8'h00;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [319:0] st;
        logic [319:0] exp;
        st = rand320();
        exp = ref_sub(st, 8'h00);
        do_start(0, st);
        wait_valid(0, lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start[0] = (i % 3 == 0);
            sti[0]   = rand320();
            @(posedge clk);
            #1;
            checks++;
            if (valid[0] !== 1'b1 || ready[0] !== 1'b0 || sto[0] !== exp) begin
                errors++;
                $display("FAIL hold_%0d valid=%b ready=%b got=%h required=%h",
                         i, valid[0], ready[0], sto[0], exp);
            end
        end
        // ack with a concurrent start must only return to idle
        @(negedge clk);
        start[0] = 1'b1;
        ack[0]   = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        ack[0]   = 1'b0;
        checks++;
        if (ready[0] !== 1'b1 || valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_release ready=%b valid=%b required 1/0", ready[0], valid[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ack_no_start ready=%b required=1", ready[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [319:0] st;
        logic [319:0] exp;
        do_start(0, rand320());
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready[0] !== 1'b1 || valid[0] !== 1'b0 || sto[0] !== '0) begin
            errors++;
            $display("FAIL mid_reset ready=%b valid=%b state=%h required 1/0/0",
                     ready[0], valid[0], sto[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        st = rand320();
        exp = ref_sub(st, 8'h00);
        do_start(0, st);
        wait_valid(0, lat);
        checks++;
        if (sto[0] !== exp || lat !== 9) begin
            errors++;
            $display("FAIL after_reset lat=%0d got=%h required=%h", lat, sto[0], exp);
        end
        do_ack(0);
    endtask

    task automatic test_sweep();
        int lat;
        int nlat;
        logic [319:0] st;
        logic [319:0] exp;
        for (int sel = 1; sel < 3; sel++) begin
            nlat = 64 / nb_of(sel) + 1;
            for (int i = 0; i < 3; i++) begin
                st = (i == 0) ? '0 : rand320();
                exp = ref_sub(st, 8'h00);
                do_start(sel, st);
                wait_valid(sel, lat);
                checks++;
                if (lat !== nlat) begin
                    errors++;
                    $display("FAIL sweep_lat nb=%0d got=%0d required=%0d", nb_of(sel), lat, nlat);
                end
                checks++;
                if (sto[sel] !== exp) begin
                    errors++;
                    $display("FAIL sweep_data nb=%0d got=%h required=%h", nb_of(sel), sto[sel], exp);
                end
                do_ack(sel);
                checks++;
                if (ready[sel] !== 1'b1 || valid[sel] !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_ack nb=%0d ready=%b valid=%b", nb_of(sel), ready[sel], valid[sel]);
                end
            end
        end
    endtask

`ifdef ASCON_ROUND_CST_EN
    task automatic test_round_cst();
        int lat;
        logic [319:0] exp;
        exp = {64'h00F0, 64'h00F0, 64'hFFFF_FFFF_FFFF_FF0F, 64'h00F0, 64'h0};
        rc = 8'hF0;
        do_start(0, '0);
        wait_valid(0, lat);
        checks++;
        if (sto[0] !== exp || lat !== 9) begin
            errors++;
            $display("FAIL round_cst lat=%0d got=%h required=%h", lat, sto[0], exp);
        end
        do_ack(0);
        rc = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_state();
        test_ones_state();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_sweep();
`ifdef ASCON_ROUND_CST_EN
        test_round_cst();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
